// File: rtl/dram_bus_responder.sv
// dram_bus_responder
// Memory-side responder for the arbitrated DRAM strobe interface. One load or
// store strobe is accepted at a time and turned into a single word-granular
// req/ack transaction on the native memory port. Load data is sign- or
// zero-extended and registered into w_dram_odata.
//
// Ports
//   CLK, RST        clock, synchronous active-high reset
//   w_dram_addr     byte address of the access
//   w_dram_wdata    right-aligned store data
//   w_dram_le       one-cycle load strobe
//   w_dram_we_t     one-cycle store strobe
//   w_dram_ctrl     access size, funct3 encoding (0 B, 1 H, 2 W, 4 BU, 5 HU)
//   w_dram_odata    registered load result
//   w_dram_busy     access in progress (combinational, high in the strobe cycle)
//   w_dram_err      registered one-cycle error pulse
//   mem_req/mem_we/mem_addr/mem_be/mem_wdata   native memory request, held until mem_ack
//   mem_ack/mem_rdata                          memory acknowledge, read data valid with ack
//   dbg_state_o     current FSM state (0 IDLE, 1 REQ, 2 DONE)
//
// Handshake: mem_req rises the cycle after an accepted strobe and stays high,
// with mem_we/mem_addr/mem_be/mem_wdata frozen, until the first cycle in which
// mem_ack is sampled high; that same edge drops mem_req and captures mem_rdata.
// mem_ack outside that window is ignored.
module dram_bus_responder #(
  parameter int unsigned ADDR_W  = 25,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [31:0]       w_dram_addr,
  input  logic [31:0]       w_dram_wdata,
  input  logic              w_dram_le,
  input  logic              w_dram_we_t,
  input  logic [2:0]        w_dram_ctrl,
  output logic [31:0]       w_dram_odata,
  output logic              w_dram_busy,
  output logic              w_dram_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic [1:0]        dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  // Last watchdog value before the abort fires; unused when TIMEOUT is 0.
  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t              state_q, state_d;
  logic [31:0]         odata_q, odata_d;
  logic                req_q, req_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [3:0]          be_q, be_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    wdog_q, wdog_d;
  logic [2:0]          ctrl_q, ctrl_d;
  logic [1:0]          off_q, off_d;

  logic                strobe;
  logic                access_ok;
  logic [1:0]          off_in;
  logic [3:0]          st_be;
  logic [31:0]         st_wdata;
  logic [31:0]         rd_shifted;
  logic [31:0]         load_val;
  logic                unused_addr_hi;

  assign strobe = w_dram_le | w_dram_we_t;
  assign off_in = w_dram_addr[1:0];

  // Address bits above the word address never reach the memory port.
  assign unused_addr_hi = ^(w_dram_addr >> (ADDR_W + 2));

  // Legality of the incoming strobe; a coincident load is dropped so the
  // store direction decides (BU/HU have no store form).
  always_comb begin
    access_ok = 1'b0;
    case (w_dram_ctrl)
      3'd0:    access_ok = 1'b1;
      3'd1:    access_ok = ~w_dram_addr[0];
      3'd2:    access_ok = (w_dram_addr[1:0] == 2'b00);
      3'd4:    access_ok = ~w_dram_we_t;
      3'd5:    access_ok = ~w_dram_we_t & ~w_dram_addr[0];
      default: access_ok = 1'b0;
    endcase
  end

  // Store lane steering: byte enables follow the offset, data is replicated
  // across lanes so the enabled lanes always carry the right bytes.
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = w_dram_wdata;
    case (w_dram_ctrl[1:0])
      2'd0: begin
        st_be    = 4'b0001 << off_in;
        st_wdata = {4{w_dram_wdata[7:0]}};
      end
      2'd1: begin
        st_be    = 4'b0011 << off_in;
        st_wdata = {2{w_dram_wdata[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = w_dram_wdata;
      end
    endcase
  end

  // Load extraction from the captured offset/size.
  assign rd_shifted = mem_rdata >> {off_q, 3'b000};

  always_comb begin
    load_val = mem_rdata;
    case (ctrl_q)
      3'd0:    load_val = {{24{rd_shifted[7]}}, rd_shifted[7:0]};
      3'd4:    load_val = {24'h000000, rd_shifted[7:0]};
      3'd1:    load_val = {{16{rd_shifted[15]}}, rd_shifted[15:0]};
      3'd5:    load_val = {16'h0000, rd_shifted[15:0]};
      default: load_val = mem_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    odata_d = odata_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    err_d   = 1'b0;
    wdog_d  = wdog_q;
    ctrl_d  = ctrl_q;
    off_d   = off_q;

    case (state_q)
      S_IDLE: begin
        if (strobe) begin
          ctrl_d = w_dram_ctrl;
          off_d  = off_in;
          wdog_d = '0;
          // Both strobes at once: the store proceeds, the load is reported.
          err_d  = w_dram_le & w_dram_we_t;
          if (access_ok) begin
            req_d   = 1'b1;
            we_d    = w_dram_we_t;
            addr_d  = w_dram_addr[ADDR_W+1:2];
            be_d    = w_dram_we_t ? st_be : 4'b1111;
            wdata_d = w_dram_we_t ? st_wdata : 32'h0;
            state_d = S_REQ;
          end else begin
            err_d   = 1'b1;
            state_d = S_DONE;
            if (!w_dram_we_t) begin
              odata_d = 32'h0;
            end
          end
        end
      end

      S_REQ: begin
        // The core ignored busy; the stray strobe is dropped.
        if (strobe) begin
          err_d = 1'b1;
        end
        if (mem_ack) begin
          req_d   = 1'b0;
          state_d = S_DONE;
          if (!we_q) begin
            odata_d = load_val;
          end
        end else if ((TIMEOUT != 0) && (wdog_q == WDOG_LAST)) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = S_DONE;
          if (!we_q) begin
            odata_d = 32'hDEADBEEF;
          end
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end

      S_DONE: begin
        if (strobe) begin
          err_d = 1'b1;
        end
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      odata_q <= 32'h0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= 4'h0;
      wdata_q <= 32'h0;
      err_q   <= 1'b0;
      wdog_q  <= '0;
      ctrl_q  <= 3'd0;
      off_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      odata_q <= odata_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      wdog_q  <= wdog_d;
      ctrl_q  <= ctrl_d;
      off_q   <= off_d;
    end
  end

  // DONE is not busy: the result is already in odata.
  assign w_dram_busy  = (state_q == S_REQ) | ((state_q == S_IDLE) & strobe);
  assign w_dram_odata = odata_q;
  assign w_dram_err   = err_q;
  assign mem_req      = req_q;
  assign mem_we       = we_q;
  assign mem_addr     = addr_q;
  assign mem_be       = be_q;
  assign mem_wdata    = wdata_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_dram_bus_responder.sv
module tb_dram_bus_responder;

  localparam int TB_TIMEOUT = 4;

  // ---------------- clock / reset ----------------
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] w_dram_addr = '0;
  logic [31:0] w_dram_wdata = '0;
  logic        w_dram_le = 1'b0;
  logic        w_dram_we_t = 1'b0;
  logic [2:0]  w_dram_ctrl = '0;
  logic [31:0] w_dram_odata;
  logic        w_dram_busy;
  logic        w_dram_err;
  logic        mem_req;
  logic        mem_we;
  logic [24:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [1:0]  dbg_state_o;

  always #5 CLK = ~CLK;

  dram_bus_responder #(.ADDR_W(25), .TIMEOUT(TB_TIMEOUT)) dut (
    .CLK(CLK), .RST(RST),
    .w_dram_addr(w_dram_addr), .w_dram_wdata(w_dram_wdata),
    .w_dram_le(w_dram_le), .w_dram_we_t(w_dram_we_t), .w_dram_ctrl(w_dram_ctrl),
    .w_dram_odata(w_dram_odata), .w_dram_busy(w_dram_busy), .w_dram_err(w_dram_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .dbg_state_o(dbg_state_o)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] ref_odata = '0;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // ---------------- reference model ----------------
  function automatic bit m_valid(input bit store, input logic [2:0] ctrl, input logic [31:0] addr);
    int bytes;
    if (ctrl == 3'd3 || ctrl >= 3'd6) return 1'b0;
    if (store && ctrl[2]) return 1'b0;
    bytes = (ctrl[1:0] == 2'd0) ? 1 : (ctrl[1:0] == 2'd1) ? 2 : 4;
    return (addr % bytes) == 0;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] ctrl, input logic [1:0] off, input logic [31:0] w);
    longint unsigned v, lim;
    int bytes;
    v = w >> (8 * off);
    bytes = (ctrl[1:0] == 2'd0) ? 1 : (ctrl[1:0] == 2'd1) ? 2 : 4;
    if (bytes < 4) begin
      lim = 64'd1 << (8 * bytes);
      v = v % lim;
      if (!ctrl[2] && v >= lim / 2) v = v + (64'h1_0000_0000 - lim);
    end
    return v[31:0];
  endfunction

  task automatic m_store(input logic [2:0] ctrl, input logic [1:0] off, input logic [31:0] w,
                         output logic [3:0] be, output logic [31:0] wd);
    int bytes;
    bytes = (ctrl[1:0] == 2'd0) ? 1 : (ctrl[1:0] == 2'd1) ? 2 : 4;
    if (bytes == 1) begin
      be = 4'(1 << off);
      wd = (w & 32'hFF) * 32'h01010101;
    end else if (bytes == 2) begin
      be = 4'(3 << off);
      wd = (w & 32'hFFFF) * 32'h00010001;
    end else begin
      be = 4'hF;
      wd = w;
    end
  endtask

  // ---------------- driver: one full access ----------------
  task automatic do_access(input bit le, input bit we, input logic [2:0] ctrl,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int ack_dly, input logic [31:0] rdata, input bit late_ack,
                           output logic [3:0] got_be, output logic [31:0] got_wd);
    bit store, valid, both, acked;
    logic [3:0]  e_be;
    logic [31:0] e_wd;
    store = we;
    both  = le && we;
    valid = m_valid(store, ctrl, addr);
    got_be = '0;
    got_wd = '0;
    m_store(ctrl, addr[1:0], wdata, e_be, e_wd);
    if (!store) e_be = 4'hF;

    w_dram_le = le; w_dram_we_t = we; w_dram_ctrl = ctrl;
    w_dram_addr = addr; w_dram_wdata = wdata;
    #1;
    check("busy_strobe", w_dram_busy, 1);
    step();
    w_dram_le = 0; w_dram_we_t = 0;
    w_dram_addr = $urandom; w_dram_wdata = $urandom; w_dram_ctrl = 3'($urandom_range(0, 7));

    if (!valid) begin
      if (!store) ref_odata = 32'h0;
      check("bad_no_req", mem_req, 0);
      check("bad_err", w_dram_err, 1);
      check("bad_busy", w_dram_busy, 0);
      check("bad_odata", w_dram_odata, ref_odata);
      step();
      check("bad_err_clr", w_dram_err, 0);
      return;
    end

    acked = 0;
    for (int k = 0; k < TB_TIMEOUT; k++) begin
      check("req_high", mem_req, 1);
      check("req_busy", w_dram_busy, 1);
      check("req_err", w_dram_err, (k == 0 && both) ? 1 : 0);
      if (k == 0) begin
        got_be = mem_be;
        got_wd = mem_wdata;
        check("mem_addr", mem_addr, (addr >> 2) & 32'h01FF_FFFF);
        check("mem_we", mem_we, store);
        check("mem_be", mem_be, e_be);
        if (store) check("mem_wdata", mem_wdata, e_wd);
      end
      if (k == ack_dly) begin
        mem_ack = 1; mem_rdata = rdata;
      end
      step();
      mem_ack = 0; mem_rdata = $urandom;
      if (k == ack_dly) begin
        acked = 1;
        break;
      end
    end

    if (!store) ref_odata = acked ? m_load(ctrl, addr[1:0], rdata) : 32'hDEADBEEF;
    check("done_req", mem_req, 0);
    check("done_busy", w_dram_busy, 0);
    check("done_err", w_dram_err, acked ? 0 : 1);
    check("done_odata", w_dram_odata, ref_odata);
    if (late_ack) begin
      mem_ack = 1; mem_rdata = $urandom;
    end
    step();
    mem_ack = 0;
    check("idle_err", w_dram_err, 0);
    check("idle_req", mem_req, 0);
    check("idle_busy", w_dram_busy, 0);
    check("idle_odata", w_dram_odata, ref_odata);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          le;
    bit          we;
    logic [2:0]  ctrl;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          ack_dly;
    logic [31:0] rdata;
    logic [31:0] exp_odata;
    bit          chk_be;
    logic [3:0]  exp_be;
    bit          chk_wd;
    logic [31:0] exp_wd;
  } vec_t;

  vec_t tbl[11];

  initial begin
    logic [3:0]  gbe;
    logic [31:0] gwd;

    tbl[0]  = '{1, 0, 3'd2, 32'h100, 32'h0, 0, 32'h89ABCDEF, 32'h89ABCDEF, 1, 4'hF, 0, 32'h0};
    tbl[1]  = '{1, 0, 3'd0, 32'h103, 32'h0, 1, 32'h80FF7F01, 32'hFFFFFF80, 1, 4'hF, 0, 32'h0};
    tbl[2]  = '{1, 0, 3'd4, 32'h103, 32'h0, 0, 32'h80FF7F01, 32'h00000080, 1, 4'hF, 0, 32'h0};
    tbl[3]  = '{1, 0, 3'd1, 32'h102, 32'h0, 2, 32'h80FF7F01, 32'hFFFF80FF, 1, 4'hF, 0, 32'h0};
    tbl[4]  = '{1, 0, 3'd5, 32'h100, 32'h0, 0, 32'h80FF7F01, 32'h00007F01, 1, 4'hF, 0, 32'h0};
    tbl[5]  = '{0, 1, 3'd0, 32'h101, 32'h12345678, 0, 32'h0, 32'h00007F01, 1, 4'b0010, 1, 32'h78787878};
    tbl[6]  = '{0, 1, 3'd1, 32'h102, 32'h12345678, 1, 32'h0, 32'h00007F01, 1, 4'b1100, 1, 32'h56785678};
    tbl[7]  = '{1, 0, 3'd2, 32'h102, 32'h0, 0, 32'h0, 32'h00000000, 0, 4'h0, 0, 32'h0};
    tbl[8]  = '{1, 1, 3'd2, 32'h200, 32'hCAFEF00D, 0, 32'h5555, 32'h00000000, 1, 4'hF, 1, 32'hCAFEF00D};
    tbl[9]  = '{1, 0, 3'd2, 32'h40, 32'h0, 9, 32'h1234, 32'hDEADBEEF, 1, 4'hF, 0, 32'h0};
    tbl[10] = '{0, 1, 3'd4, 32'h0, 32'h1, 0, 32'h0, 32'hDEADBEEF, 0, 4'h0, 0, 32'h0};

    // reset
    RST = 1;
    step();
    step();
    check("rst_odata", w_dram_odata, 0);
    check("rst_req", mem_req, 0);
    check("rst_busy", w_dram_busy, 0);
    check("rst_err", w_dram_err, 0);
    check("rst_be", mem_be, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_we", mem_we, 0);
    RST = 0;
    step();

    // table vectors
    for (int i = 0; i < 11; i++) begin
      do_access(tbl[i].le, tbl[i].we, tbl[i].ctrl, tbl[i].addr, tbl[i].wdata,
                tbl[i].ack_dly, tbl[i].rdata, 1'b1, gbe, gwd);
      check("tbl_odata", w_dram_odata, tbl[i].exp_odata);
      if (tbl[i].chk_be) check("tbl_be", gbe, tbl[i].exp_be);
      if (tbl[i].chk_wd) check("tbl_wd", gwd, tbl[i].exp_wd);
    end

    // strobe while REQ, then strobe while DONE
    w_dram_le = 1; w_dram_ctrl = 3'd2; w_dram_addr = 32'h10;
    step();
    w_dram_le = 1; w_dram_ctrl = 3'd0; w_dram_addr = 32'h55;
    step();
    w_dram_le = 0;
    check("rq_strobe_err", w_dram_err, 1);
    check("rq_strobe_req", mem_req, 1);
    check("rq_strobe_addr", mem_addr, 32'h4);
    check("rq_strobe_busy", w_dram_busy, 1);
    mem_ack = 1; mem_rdata = 32'h11223344;
    step();
    mem_ack = 0;
    ref_odata = 32'h11223344;
    check("rq_strobe_odata", w_dram_odata, ref_odata);
    check("rq_strobe_err_clr", w_dram_err, 0);
    w_dram_le = 1; w_dram_addr = 32'h20;
    #1;
    check("done_strobe_busy", w_dram_busy, 0);
    step();
    w_dram_le = 0;
    check("done_strobe_err", w_dram_err, 1);
    check("done_strobe_req", mem_req, 0);
    check("done_strobe_odata", w_dram_odata, ref_odata);
    step();
    check("done_strobe_err_clr", w_dram_err, 0);

    // reset during REQ, ack arrives later
    w_dram_le = 1; w_dram_ctrl = 3'd2; w_dram_addr = 32'h300;
    step();
    w_dram_le = 0;
    check("rr_req", mem_req, 1);
    step();
    RST = 1;
    step();
    RST = 0;
    ref_odata = 32'h0;
    check("rr_req0", mem_req, 0);
    check("rr_odata", w_dram_odata, 0);
    check("rr_err", w_dram_err, 0);
    check("rr_busy", w_dram_busy, 0);
    check("rr_be", mem_be, 0);
    check("rr_addr", mem_addr, 0);
    check("rr_wdata", mem_wdata, 0);
    check("rr_we", mem_we, 0);
    for (int k = 0; k < 6; k++) step();
    mem_ack = 1; mem_rdata = 32'hFFFF_FFFF;
    step();
    mem_ack = 0;
    check("rr_late_req", mem_req, 0);
    check("rr_late_odata", w_dram_odata, 0);
    check("rr_late_err", w_dram_err, 0);
    do_access(1, 0, 3'd2, 32'h800, 32'h0, 1, 32'hA5A50F0F, 0, gbe, gwd);
    check("rr_follow_odata", w_dram_odata, 32'hA5A50F0F);

    // randomized accesses against the model
    for (int n = 0; n < 40; n++) begin
      int r;
      r = $urandom_range(1, 3);
      do_access(r[0], r[1], 3'($urandom_range(0, 7)), $urandom, $urandom,
                $urandom_range(0, 5), $urandom, 1'($urandom_range(0, 1)), gbe, gwd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
